fetch: RTL

//  Instruction fetch stage: owns the PC, issues word reads on the instruction bus and

---
 rtl/fetch_pkg.sv | 41 ++++
 rtl/fetch_pc_gen.sv | 60 ++++++
 rtl/fetch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction fetch stage.
//   - CPU_ADDR_WIDTH / CPU_INSTR_WIDTH : address and instruction widths
//   - NOP_INSTR                        : instruction presented when nothing valid
//   - fetchState_t                     : fetch FSM states
//   - nextSeqPc()                      : sequential PC step (wraps naturally)
//   Configuration macro: CPU_FETCH_ALIGN_CHECK_EN adds the ST_ERR state.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_INSTR_WIDTH = 32;

    localparam logic [CPU_INSTR_WIDTH-1:0] NOP_INSTR  = '0;
    localparam logic [CPU_ADDR_WIDTH-1:0]  PC_STEP    = 32'd4;
    localparam logic [CPU_ADDR_WIDTH-1:0]  ALIGN_MASK = 32'hFFFF_FFFC;

    // REQ  : request on the bus, waiting for accept
    // WAIT : request accepted, waiting for read data
    // HOLD : data captured because decode could not take it yet
    // KILL : a response is still in flight but belongs to a dropped fetch
    // ERR  : parked after a misaligned redirect
    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_KILL
`ifdef CPU_FETCH_ALIGN_CHECK_EN
        , ST_ERR
`endif
    } fetchState_t;

    // The add is done at full address width, so 32'hFFFF_FFFC steps to 0.
    function automatic logic [CPU_ADDR_WIDTH-1:0] nextSeqPc(
        input logic [CPU_ADDR_WIDTH-1:0] pc
    );
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Owns the fetch PC register: sequential +4 advance, redirect load and the
//   alignment check on redirect targets.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     i_advance       current instruction consumed, step PC by 4
//     i_redirect      redirect request (has priority over i_advance)
//     i_target        redirect target address
//     o_pc            current fetch PC
//     o_misaligned    redirect with a misaligned target this cycle
//   Configuration macro: CPU_FETCH_ALIGN_CHECK_EN
//     defined   : misaligned targets are flagged and do not load the PC
//     undefined : target low bits are forced to zero, flag tied low
// -----------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_advance,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);

    logic [31:0] r_pc;
    logic [31:0] w_target;

    // Word-align the target. With the check enabled a misaligned target never
    // reaches the PC, so the mask only matters in the unchecked build.
    assign w_target = i_target & ALIGN_MASK;

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    assign o_misaligned = i_redirect && (i_target[1:0] != 2'b00);
`else
    assign o_misaligned = 1'b0;
`endif

    // PC register: redirect wins over the sequential step because a consumed
    // instruction and a redirect never coincide (presentation is suppressed
    // on redirect cycles), but the priority keeps that explicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            if (!o_misaligned) begin
                r_pc <= w_target;
            end
        end else if (i_advance) begin
            r_pc <= nextSeqPc(r_pc);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//   Instruction fetch stage. Issues one word read at a time on the instruction
//   bus and presents the pc/instr pair to decode. Redirects from execute drop
//   any fetch that has not yet been consumed.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     i_exec_stall, i_mem_stall      downstream stalls (block consumption)
//     i_jump, i_jump_addr            redirect pulse and target
//     o_pc, o_instr                  presented PC and instruction
//     o_fetch_stall                  1 = nothing valid presented this cycle
//     o_addr_err                     misaligned redirect pulse
//     o_imem_addr, o_imem_cmd        bus read address / request
//     i_imem_cmd_ack                 request accepted this cycle
//     i_imem_rdata, i_imem_rdata_vld read data and its valid
//   Configuration macro: CPU_FETCH_ALIGN_CHECK_EN enables the misaligned
//   redirect check and the ERR state; otherwise o_addr_err stays 0.
// -----------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exec_stall,
    input  logic        i_mem_stall,
    input  logic        i_jump,
    input  logic [31:0] i_jump_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_fetch_stall,
    output logic        o_addr_err,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_cmd,
    input  logic        i_imem_cmd_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_rdata_vld
);

    fetchState_t r_state;
    logic [31:0] r_holdInstr;
    logic        r_addrErr;

    logic [31:0] w_pc;
    logic        w_misaligned;
    logic        w_present;
    logic [31:0] w_presentInstr;
    logic        w_consumed;

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    logic        r_drainPending;
    logic        w_respInFlight;
`endif

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pcGen (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_consumed),
        .i_redirect   (i_jump),
        .i_target     (i_jump_addr),
        .o_pc         (w_pc),
        .o_misaligned (w_misaligned)
    );

    // Presentation: read data is forwarded combinationally in WAIT, the held
    // copy is shown in HOLD. A redirect hides whatever would be presented so
    // decode never takes an instruction from the abandoned path.
    always_comb begin
        w_present      = 1'b0;
        w_presentInstr = NOP_INSTR;
        if (!i_jump) begin
            if (r_state == ST_WAIT && i_imem_rdata_vld) begin
                w_present      = 1'b1;
                w_presentInstr = i_imem_rdata;
            end else if (r_state == ST_HOLD) begin
                w_present      = 1'b1;
                w_presentInstr = r_holdInstr;
            end
        end
    end

    assign w_consumed    = w_present & ~i_exec_stall & ~i_mem_stall;
    assign o_fetch_stall = ~w_present;
    assign o_instr       = w_presentInstr;
    assign o_pc          = w_pc;
    assign o_addr_err    = r_addrErr;

    // The request is gated by rst so it stays low while reset is held and
    // rises in the very first cycle after reset is released.
    assign o_imem_cmd  = (r_state == ST_REQ) & ~rst;
    assign o_imem_addr = w_pc;

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    // A bus response will still arrive for the current transaction after this
    // cycle; ERR must swallow it before a new request may go out.
    always_comb begin
        w_respInFlight = 1'b0;
        unique case (r_state)
            ST_REQ:  w_respInFlight = i_imem_cmd_ack;
            ST_WAIT: w_respInFlight = ~i_imem_rdata_vld;
            ST_KILL: w_respInFlight = ~i_imem_rdata_vld;
            ST_ERR:  w_respInFlight = r_drainPending & ~i_imem_rdata_vld;
            default: w_respInFlight = 1'b0;
        endcase
    end
`endif

    // Fetch FSM. Redirects are taken regardless of stalls. An unacked request
    // being redirected has nothing in flight, so it simply re-requests at the
    // new PC instead of waiting in KILL for a response that never comes.
    // A response arriving in the same cycle as a redirect is already drained,
    // so KILL and ERR can leave immediately in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_holdInstr <= NOP_INSTR;
            r_addrErr   <= 1'b0;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
            r_drainPending <= 1'b0;
`endif
        end else begin
            r_addrErr <= i_jump & w_misaligned;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
            if (i_jump && w_misaligned) begin
                r_state        <= ST_ERR;
                r_drainPending <= w_respInFlight;
            end else
`endif
            if (i_jump) begin
                unique case (r_state)
                    ST_REQ:  r_state <= i_imem_cmd_ack   ? ST_KILL : ST_REQ;
                    ST_WAIT: r_state <= i_imem_rdata_vld ? ST_REQ  : ST_KILL;
                    ST_HOLD: r_state <= ST_REQ;
                    ST_KILL: r_state <= i_imem_rdata_vld ? ST_REQ  : ST_KILL;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
                    ST_ERR: begin
                        r_state        <= w_respInFlight ? ST_KILL : ST_REQ;
                        r_drainPending <= 1'b0;
                    end
`endif
                    default: r_state <= ST_REQ;
                endcase
            end else begin
                unique case (r_state)
                    ST_REQ: begin
                        if (i_imem_cmd_ack) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (i_imem_rdata_vld) begin
                            if (w_consumed) begin
                                r_state <= ST_REQ;
                            end else begin
                                r_holdInstr <= i_imem_rdata;
                                r_state     <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_consumed) begin
                            r_state <= ST_REQ;
                        end
                    end
                    ST_KILL: begin
                        if (i_imem_rdata_vld) begin
                            r_state <= ST_REQ;
                        end
                    end
`ifdef CPU_FETCH_ALIGN_CHECK_EN
                    ST_ERR: begin
                        if (i_imem_rdata_vld) begin
                            r_drainPending <= 1'b0;
                        end
                    end
`endif
                    default: r_state <= ST_REQ;
                endcase
            end
        end
    end

endmodule
